// File: rtl/id_ix_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the ID/IX hazard controller.
// The datapath (master) reports ID/IX/MEM status; the controller (slave) returns stall/flush controls.
interface id_ix_hazard_ctrl_if;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ix_valid;
  logic [4:0]  ix_dest;
  logic        ix_write_to_reg;
  logic        ix_is_load;
  logic        ix_redirect;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_stall;
  logic        if_id_stall;
  logic        if_id_flush;
  logic        id_ix_stall;
  logic        id_ix_bubble;
  logic        ex_mem_stall;
  logic [31:0] stall_count;
  logic [15:0] redirect_count;
  logic [1:0]  state;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rt, ix_valid, ix_dest, ix_write_to_reg,
           ix_is_load, ix_redirect, mem_req, mem_ready,
    input  pc_stall, if_id_stall, if_id_flush, id_ix_stall, id_ix_bubble, ex_mem_stall,
           stall_count, redirect_count, state
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rt, ix_valid, ix_dest, ix_write_to_reg,
           ix_is_load, ix_redirect, mem_req, mem_ready,
    output pc_stall, if_id_stall, if_id_flush, id_ix_stall, id_ix_bubble, ex_mem_stall,
           stall_count, redirect_count, state
  );
endinterface

// File: rtl/id_ix_hazard_ctrl.sv
// ID/IX hazard controller: load-use bubbles, IX redirect flushes and data-memory wait holds,
// with saturating stall/redirect performance counters.
module id_ix_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  id_ix_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MEM_WAIT   = 2'd2
  } state_t;

  localparam bit         MULTI_STALL = (LOAD_STALL_CYCLES > 32'd1);
  localparam logic [2:0] CNT_INIT    = MULTI_STALL ? 3'(LOAD_STALL_CYCLES - 32'd2) : 3'd0;

  state_t      state_r;
  state_t      state_nxt_s;
  state_t      ret_r;
  state_t      ret_nxt_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nxt_s;
  logic [31:0] stall_cnt_r;
  logic [15:0] redir_cnt_r;

  logic memwait_s;
  logic lu_hazard_s;
  logic pc_stall_s;
  logic if_id_stall_s;
  logic if_id_flush_s;
  logic id_ix_stall_s;
  logic id_ix_bubble_s;
  logic ex_mem_stall_s;
  logic redirect_take_s;

  assign memwait_s   = bus.mem_req & ~bus.mem_ready;
  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign lu_hazard_s = bus.ix_valid & bus.ix_is_load & bus.ix_write_to_reg &
                       (bus.ix_dest != 5'd0) & bus.id_valid &
                       ((bus.ix_dest == bus.id_rs) | (bus.id_uses_rt & (bus.ix_dest == bus.id_rt)));

  // FSM state, bubble counter and return-state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_RUN;
      ret_r   <= ST_RUN;
      cnt_r   <= 3'd0;
    end else begin
      state_r <= state_nxt_s;
      ret_r   <= ret_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic; memwait outranks redirect, which outranks load-use.
  always_comb begin
    state_nxt_s = state_r;
    ret_nxt_s   = ret_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_RUN: begin
        if (memwait_s) begin
          state_nxt_s = ST_MEM_WAIT;
          ret_nxt_s   = ST_RUN;
        end else if (bus.ix_redirect) begin
          state_nxt_s = ST_RUN;
        end else if (lu_hazard_s && MULTI_STALL) begin
          state_nxt_s = ST_LOAD_STALL;
          cnt_nxt_s   = CNT_INIT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_LOAD_STALL: begin
        if (memwait_s) begin
          state_nxt_s = ST_MEM_WAIT;
          ret_nxt_s   = ST_LOAD_STALL;
        end else if (cnt_r == 3'd0) begin
          state_nxt_s = ST_RUN;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_nxt_s = ret_r;
        end else begin
          state_nxt_s = ST_MEM_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        ret_nxt_s   = ST_RUN;
        cnt_nxt_s   = 3'd0;
      end
    endcase
  end

  // Control outputs; forced quiet while reset is asserted.
  always_comb begin
    pc_stall_s      = 1'b0;
    if_id_stall_s   = 1'b0;
    if_id_flush_s   = 1'b0;
    id_ix_stall_s   = 1'b0;
    id_ix_bubble_s  = 1'b0;
    ex_mem_stall_s  = 1'b0;
    redirect_take_s = 1'b0;
    if (!rst_n) begin
      pc_stall_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (memwait_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ix_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
          end else if (bus.ix_redirect) begin
            if_id_flush_s   = 1'b1;
            id_ix_bubble_s  = 1'b1;
            redirect_take_s = 1'b1;
          end else if (lu_hazard_s) begin
            pc_stall_s     = 1'b1;
            if_id_stall_s  = 1'b1;
            id_ix_bubble_s = 1'b1;
          end else begin
            pc_stall_s = 1'b0;
          end
        end
        ST_LOAD_STALL: begin
          pc_stall_s    = 1'b1;
          if_id_stall_s = 1'b1;
          if (memwait_s) begin
            id_ix_stall_s  = 1'b1;
            ex_mem_stall_s = 1'b1;
          end else begin
            id_ix_bubble_s = 1'b1;
          end
        end
        ST_MEM_WAIT: begin
          pc_stall_s     = 1'b1;
          if_id_stall_s  = 1'b1;
          id_ix_stall_s  = 1'b1;
          ex_mem_stall_s = 1'b1;
        end
        default: begin
          pc_stall_s = 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_r <= 32'd0;
      redir_cnt_r <= 16'd0;
    end else begin
      if (pc_stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (redirect_take_s && (redir_cnt_r != 16'hFFFF)) begin
        redir_cnt_r <= redir_cnt_r + 16'd1;
      end
    end
  end

  assign bus.pc_stall       = pc_stall_s;
  assign bus.if_id_stall    = if_id_stall_s;
  assign bus.if_id_flush    = if_id_flush_s;
  assign bus.id_ix_stall    = id_ix_stall_s;
  assign bus.id_ix_bubble   = id_ix_bubble_s;
  assign bus.ex_mem_stall   = ex_mem_stall_s;
  assign bus.stall_count    = stall_cnt_r;
  assign bus.redirect_count = redir_cnt_r;
  assign bus.state          = state_r;

endmodule
